// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM pipeline stage with handshaked load/store port, alignment and stall control
module mem_lsu_stage #(
  parameter int STALL_W = 6,
  parameter int MEM_IDX = 3,
  parameter int SIDE_W  = 66
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic [4:0]         ex_op_load,
  input  logic [2:0]         ex_op_store,
  input  logic [31:0]        ex_result,
  input  logic [31:0]        ex_store_data,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic [SIDE_W-1:0]  ex_side,
  output logic               data_req,
  output logic               data_wr,
  output logic [1:0]         data_size,
  output logic [31:0]        data_addr,
  output logic [3:0]         data_wstrb,
  output logic [31:0]        data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [31:0]        data_rdata,
  output logic               stallreq_mem,
  output logic               wb_valid,
  output logic [31:0]        wb_pc,
  output logic               wb_rf_we,
  output logic [4:0]         wb_rf_waddr,
  output logic [31:0]        wb_rf_wdata,
  output logic [SIDE_W-1:0]  wb_side,
  output logic               fwd_pending,
  output logic               exc_adel,
  output logic               exc_ades
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t             state_q;
  logic               valid_q, rf_we_q;
  logic [31:0]        pc_q, addr_q, sdata_q, rdata_q;
  logic [4:0]         ld_q, waddr_q;
  logic [2:0]         st_q;
  logic [SIDE_W-1:0]  side_q;
  logic               is_ld, is_st, is_mem, mis, req;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [31:0]        load_v;
  logic               unused_stall;

  // lw/sw need word alignment, halfword ops need even addresses, bytes never trap
  function automatic logic misal(input logic [4:0] ld, input logic [2:0] st, input logic [1:0] a);
    return ((ld[0] | st[0]) & (|a)) | ((ld[3] | ld[4] | st[2]) & a[0]);
  endfunction

  assign unused_stall = ^stall;

  // stage register plus access FSM; every register load restarts the FSM
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {valid_q, pc_q, ld_q, st_q, addr_q, sdata_q, rf_we_q, waddr_q, side_q} <= '0;
      state_q <= IDLE;
    end else if (stall[MEM_IDX] && !stall[MEM_IDX+1]) begin
      {valid_q, pc_q, ld_q, st_q, addr_q, sdata_q, rf_we_q, waddr_q, side_q} <= '0;
      state_q <= IDLE;
    end else if (!stall[MEM_IDX]) begin
      {valid_q, pc_q, ld_q, st_q, addr_q, sdata_q, rf_we_q, waddr_q, side_q} <=
        {ex_valid, ex_pc, ex_op_load, ex_op_store, ex_result, ex_store_data, ex_rf_we, ex_rf_waddr, ex_side};
      state_q <= (ex_valid && (|ex_op_load || |ex_op_store) && !misal(ex_op_load, ex_op_store, ex_result[1:0]))
                 ? REQ : IDLE;
    end else
      case (state_q)
        REQ:     if (data_addr_ok) state_q <= data_data_ok ? DONE : WAIT;
        WAIT:    if (data_data_ok) state_q <= DONE;
        default: ;
      endcase

  // capture the response only while an access is outstanding; stray data_ok is ignored
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else if (data_data_ok && (state_q == REQ || state_q == WAIT)) rdata_q <= data_rdata;

  assign is_ld  = valid_q & (|ld_q);
  assign is_st  = valid_q & (|st_q);
  assign is_mem = is_ld | is_st;
  assign mis    = is_mem & misal(ld_q, st_q, addr_q[1:0]);
  assign req    = is_mem & (state_q == REQ);

  assign data_req   = req;
  assign data_wr    = req & (|st_q);
  assign data_addr  = req ? addr_q : '0;
  assign data_size  = !req ? 2'd0 : (ld_q[0] | st_q[0]) ? 2'd2 : (ld_q[3] | ld_q[4] | st_q[2]) ? 2'd1 : 2'd0;
  assign data_wstrb = !data_wr ? 4'b0000 : st_q[0] ? 4'b1111 :
                      st_q[2] ? 4'b0011 << addr_q[1:0] : 4'b0001 << addr_q[1:0];
  assign data_wdata = !data_wr ? '0 : st_q[0] ? sdata_q :
                      st_q[2] ? {2{sdata_q[15:0]}} : {4{sdata_q[7:0]}};

  assign byte_v = 8'(rdata_q >> {addr_q[1:0], 3'b000});
  assign half_v = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign load_v = ld_q[0] ? rdata_q :
                  ld_q[1] ? {{24{byte_v[7]}}, byte_v} :
                  ld_q[2] ? {24'b0, byte_v} :
                  ld_q[3] ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};

  assign stallreq_mem = is_mem & (state_q == REQ || state_q == WAIT);
  assign wb_valid     = valid_q & !stallreq_mem;
  assign wb_pc        = pc_q;
  assign wb_rf_we     = rf_we_q & valid_q & !mis & !stallreq_mem;
  assign wb_rf_waddr  = waddr_q;
  assign wb_rf_wdata  = is_ld ? load_v : addr_q;
  assign wb_side      = wb_valid ? side_q : '0;
  assign fwd_pending  = is_ld & (state_q != DONE) & !mis;
  assign exc_adel     = mis & is_ld;
  assign exc_ades     = mis & is_st;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: directed-vector bench for the MEM load/store stage
module tb_mem_lsu_stage;
  logic        clk = 0, rst = 1;
  logic [5:0]  stall, stall_ext = '0;
  logic        ex_valid = 0, ex_rf_we = 0;
  logic [31:0] ex_pc = '0, ex_result = '0, ex_store_data = '0;
  logic [4:0]  ex_op_load = '0, ex_rf_waddr = '0;
  logic [2:0]  ex_op_store = '0;
  logic [65:0] ex_side = '0;
  logic        data_req, data_wr, data_addr_ok = 0, data_data_ok = 0;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata = '0;
  logic [3:0]  data_wstrb;
  logic        stallreq_mem, wb_valid, wb_rf_we, fwd_pending, exc_adel, exc_ades;
  logic [31:0] wb_pc, wb_rf_wdata;
  logic [4:0]  wb_rf_waddr;
  logic [65:0] wb_side;
  int          n_run = 0, n_fail = 0, cnt;

  localparam logic [4:0] LW = 5'b00001, LB = 5'b00010, LH = 5'b01000, LHU = 5'b10000;
  localparam logic [2:0] SW = 3'b001, SB = 3'b010, SH = 3'b100;

  // a memory stall holds MEM and WB registers, like the pipeline controller would
  assign stall = stall_ext | (stallreq_mem ? 6'b011111 : 6'b000000);

  mem_lsu_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_load(ex_op_load), .ex_op_store(ex_op_store),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_side(ex_side),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stallreq_mem(stallreq_mem), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .wb_side(wb_side),
    .fwd_pending(fwd_pending), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present one instruction for a single load edge, then drain EX
  task automatic issue(input logic [4:0] ld, input logic [2:0] st, input logic [31:0] res,
                       input logic [31:0] sd, input logic we, input logic [65:0] side);
    ex_valid = 1; ex_pc = 32'h400 + res; ex_op_load = ld; ex_op_store = st;
    ex_result = res; ex_store_data = sd; ex_rf_we = we; ex_rf_waddr = 5'd9; ex_side = side;
    @(posedge clk); #1;
    ex_valid = 0; ex_op_load = '0; ex_op_store = '0; ex_result = '0; ex_rf_we = 0; ex_side = '0;
  endtask

  // acknowledge address and data together for one cycle
  task automatic ack(input logic [31:0] rd);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = rd;
    @(posedge clk); #1;
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  initial begin
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req", data_req, 0);
    check("rst_stall", stallreq_mem, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    issue(LB, 3'b000, 32'h1003, 0, 1, 66'h5);
    check("lb_stall", stallreq_mem, 1);
    check("lb_req", data_req, 1);
    check("lb_addr", data_addr, 32'h1003);
    check("lb_size", data_size, 0);
    check("lb_wr", data_wr, 0);
    check("lb_fwd_pend", fwd_pending, 1);
    ack(32'h80AB_CD12);
    check("lb_done_stall", stallreq_mem, 0);
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wdata", wb_rf_wdata, 32'hFFFF_FF80);
    check("lb_we", wb_rf_we, 1);
    check("lb_side", wb_side, 66'h5);

    issue(LHU, 3'b000, 32'h2002, 0, 1, 0);
    check("lhu_size", data_size, 1);
    cnt = 0;
    for (int c = 0; c < 20 && stallreq_mem; c++) begin
      data_addr_ok = (c == 0); data_data_ok = (c == 3);
      data_rdata = (c == 3) ? 32'hBEEF_0000 : 32'h0;
      if (c == 2) check("lhu_wait_req", data_req, 0);
      if (c == 2) check("lhu_wait_fwd", fwd_pending, 1);
      cnt++;
      @(posedge clk); #1;
    end
    data_addr_ok = 0; data_data_ok = 0;
    check("lhu_stall_cycles", cnt, 4);
    check("lhu_wdata", wb_rf_wdata, 32'h0000_BEEF);
    check("lhu_fwd_fall", fwd_pending, 0);
    stall_ext = 6'b011111;
    @(posedge clk); #1;
    check("hold_wdata", wb_rf_wdata, 32'h0000_BEEF);
    check("hold_no_req", data_req, 0);
    check("hold_valid", wb_valid, 1);
    stall_ext = '0;

    issue(3'b000 == 0 ? 5'b0 : 5'b0, SB, 32'h13, 32'h5A, 0, 0);
    check("sb_wr", data_wr, 1);
    check("sb_wstrb", data_wstrb, 4'b1000);
    check("sb_wdata", data_wdata, 32'h5A5A_5A5A);
    ack(0);
    check("sb_done", wb_valid, 1);
    issue(5'b0, SH, 32'h12, 32'h1234, 0, 0);
    check("sh_wstrb", data_wstrb, 4'b1100);
    check("sh_wdata", data_wdata, 32'h1234_1234);
    check("sh_size", data_size, 1);
    ack(0);
    issue(5'b0, SW, 32'h20, 32'hCAFE_0001, 0, 0);
    check("sw_wstrb", data_wstrb, 4'b1111);
    check("sw_size", data_size, 2);
    ack(0);

    issue(LW, 3'b000, 32'h4001, 0, 1, 0);
    check("mis_lw_adel", exc_adel, 1);
    check("mis_lw_req", data_req, 0);
    check("mis_lw_we", wb_rf_we, 0);
    check("mis_lw_stall", stallreq_mem, 0);
    check("mis_lw_fwd", fwd_pending, 0);
    issue(5'b0, SH, 32'h3, 32'h77, 0, 0);
    check("mis_sh_ades", exc_ades, 1);
    check("mis_sh_adel", exc_adel, 0);
    check("mis_sh_req", data_req, 0);

    issue(5'b0, 3'b000, 32'h7, 0, 1, 66'h2_DEAD_BEEF_1234_5678);
    check("alu_stall", stallreq_mem, 0);
    check("alu_wdata", wb_rf_wdata, 32'h7);
    check("alu_we", wb_rf_we, 1);
    check("alu_side", wb_side, 66'h2_DEAD_BEEF_1234_5678);
    stall_ext = 6'b001111;
    @(posedge clk); #1;
    check("bubble_valid", wb_valid, 0);
    check("bubble_side", wb_side, 0);
    stall_ext = '0;

    issue(LW, 3'b000, 32'h100, 0, 1, 0);
    data_addr_ok = 1;
    @(posedge clk); #1;
    data_addr_ok = 0;
    check("rstmid_wait", stallreq_mem, 1);
    rst = 1; #1;
    check("rstmid_stall", stallreq_mem, 0);
    check("rstmid_valid", wb_valid, 0);
    check("rstmid_fwd", fwd_pending, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    data_data_ok = 1; data_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    data_data_ok = 0;
    check("late_ok_stall", stallreq_mem, 0);
    check("late_ok_req", data_req, 0);
    issue(LH, 3'b000, 32'h202, 0, 1, 0);
    check("after_rst_req", data_req, 1);
    ack(32'h8001_CAFE);
    check("after_rst_wdata", wb_rf_wdata, 32'hFFFF_8001);
    check("after_rst_valid", wb_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised MEM pipeline stage with a handshaked data-memory port, sitting between EX and WB. It replaces the fixed-latency MEM stage, which read `data_sram_rdata` combinationally. This stage issues its own load/store request on an addr_ok/data_ok interface, so memory latency can vary. It stalls the pipeline until the access completes, performs load sign/zero extension and store lane alignment, and flags misaligned accesses. Non-memory results, plus a generic side-band field (hi/lo write-back), pass through to WB and to ID forwarding.

## Interface
- `STALL_W`, 6: width of the pipeline stall vector.
- `MEM_IDX`, 3: index of this stage in `stall`. `MEM_IDX+1` is the WB bit.
- `SIDE_W`, 66: width of the pass-through side-band field (hi_we, lo_we, hi, lo).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in STALL_W: `Stop`=1 per stage.
- `ex_valid` in 1: EX slot holds a real instruction.
- `ex_pc` in 32: instruction PC.
- `ex_op_load` in 5: one-hot, bits {lhu,lh,lbu,lb,lw} = [4:0].
- `ex_op_store` in 3: one-hot, bits {sh,sb,sw} = [2:0].
- `ex_result` in 32: ALU result; the effective address for memory ops.
- `ex_store_data` in 32: rt value for stores.
- `ex_rf_we` in 1, `ex_rf_waddr` in 5: register write-back control.
- `ex_side` in SIDE_W: side-band field, carried unchanged to the outputs.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2 (0 byte, 1 half, 2 word), `data_addr` out 32, `data_wstrb` out 4, `data_wdata` out 32: memory request channel.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32: memory acknowledge and response.
- `stallreq_mem` out 1: the access is not yet complete.
- `wb_valid` out 1, `wb_pc` out 32, `wb_rf_we` out 1, `wb_rf_waddr` out 5, `wb_rf_wdata` out 32, `wb_side` out SIDE_W: outputs to WB.
- `fwd_pending` out 1: the ID forwarding copy, which is the same as the `wb_*` fields, is not yet usable (load data outstanding).
- `exc_adel` out 1, `exc_ades` out 1: misaligned load or store.

## Operation
- **Stage register update (priority order):**
  - `rst` clears it to all zero.
  - If `stall[MEM_IDX]`=1 and `stall[MEM_IDX+1]`=0, load a bubble (all zero).
  - Else if `stall[MEM_IDX]`=0, load the EX fields.
  - Otherwise hold.
- **Memory operation:** the register is a memory op when `valid` and (|op_load or |op_store).
- **Misalignment:**
  - lw/sw are misaligned when addr[1:0]≠0.
  - lh/lhu/sh are misaligned when addr[0]≠0.
  - A misaligned op raises `exc_adel` (loads) or `exc_ades` (stores).
  - It issues no request, forces `wb_rf_we`=0, and is complete immediately.
- **FSM (`state` register):**
  - IDLE: no memory op pending, or the op is complete.
  - REQ: `data_req`=1.
    - `data_addr_ok`=1 and `data_data_ok`=0 → WAIT.
    - `data_addr_ok`=1 and `data_data_ok`=1 in the same cycle → DONE.
  - WAIT: `data_req`=0. `data_data_ok`=1 → DONE.
  - DONE: the access is complete; `rdata_r` holds the captured response.
  - On each cycle the stage register loads (new instruction or bubble), the next state is REQ if the loaded value is an aligned memory op, else IDLE.
- **Request fields:**
  - `data_addr`=addr, `data_wr`=|op_store.
  - `data_size`: 2 for lw/sw, 1 for half ops, 0 for byte ops.
  - Fields are valid only while `data_req`=1, otherwise 0.
- **Store alignment:**
  - sw: `data_wstrb`=4'b1111, `data_wdata`=data.
  - sh: `data_wstrb`=4'b0011 << addr[1:0], `data_wdata`={2{data[15:0]}}.
  - sb: `data_wstrb`=4'b0001 << addr[1:0], `data_wdata`={4{data[7:0]}}.
  - Loads: `data_wstrb`=0.
- **Response capture:** `rdata_r` is latched on `data_data_ok`, in both REQ and WAIT.
- **Load extraction from `rdata_r`:**
  - lw: the whole word.
  - lb/lbu: byte addr[1:0], sign- or zero-extended.
  - lh/lhu: half addr[1], sign- or zero-extended.
- **Write data:** `wb_rf_wdata` = extracted load value for loads, else `ex_result`.
- **Stall and completion:**
  - `stallreq_mem` = memory op and state ∈ {REQ, WAIT}.
  - `wb_valid` = valid and not `stallreq_mem`.
  - `fwd_pending` = valid load with state ≠ DONE and no misalignment.
  - While `stallreq_mem`=1, `wb_rf_we`=0.
- **Side-band:** `wb_side` = stored `ex_side` gated by `wb_valid`.

## Timing
- **Reset:** all outputs 0 and state IDLE, asynchronously on `rst` and held until `rst` falls.
- **Reset during REQ/WAIT:** abandon the access; a later `data_data_ok` arriving in IDLE is ignored.
- **Latency:** minimum one extra cycle per memory op. Register loaded at edge N; REQ in cycle N; `data_addr_ok`+`data_data_ok` in cycle N; completion visible in cycle N+1.
- **Non-memory instructions:** zero added latency.
- **Request hold:** `data_req` and its fields stay stable until `data_addr_ok`.
- **Early response:** the stage never drops the request; a `data_data_ok` before `data_addr_ok` is not permitted.
- **Hold after completion:** after DONE, the stage keeps its outputs stable while held by downstream stall, and re-issues nothing.

## Test plan
- **lb, zero-wait:** addr 0x1003, memory returns 0x80AB_CD12 with addr_ok/data_ok in the same cycle → one stall cycle, `wb_rf_wdata`=0xFFFF_FF80.
- **lhu with latency:** addr 0x2002, data_ok 3 cycles after addr_ok, rdata 0xBEEF_0000 → `stallreq_mem` high 4 cycles, then 0x0000_BEEF, `fwd_pending` falls the same cycle.
- **Stores:** sb addr 0x13, data 0x5A → wstrb 4'b1000, wdata 0x5A5A_5A5A. sh addr 0x12, data 0x1234 → wstrb 4'b1100.
- **Misaligned:** lw addr 0x4001 → `exc_adel`=1, no `data_req`, `wb_rf_we`=0, no stall. sh addr 0x3 → `exc_ades`=1.
- **Bubble insertion:** `stall` MEM=1, WB=0 → `wb_valid`=0 next cycle. addu result 0x7 with `ex_side`=X → passes through with zero stall.
- **Reset mid-access:** `rst` asserted in WAIT → outputs 0 immediately. A late data_ok is ignored, and the next load completes normally.
